// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and executor load/store, one transaction at a time.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: fetch always wins over data instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_ready,

    input  logic [ADDR_W-1:0] load_addr,
    input  logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              load_ready,

    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic              store_valid,
    output logic              store_ready,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RD = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    localparam logic [1:0] G_FETCH = 2'd0;
    localparam logic [1:0] G_LOAD  = 2'd1;
    localparam logic [1:0] G_STORE = 2'd2;

    logic [1:0] state;
    logic [1:0] grant;

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Set when the data side (load or store) held the most recent grant.
    logic rr_last_data;
`endif

    logic       data_pend;
    logic       take_any;
    logic       take_fetch;
    logic [1:0] next_grant;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        data_pend  = store_valid | load_valid;
        take_any   = fetch_valid | data_pend;
`ifdef MEM_ARB_FIXED_PRIO_EN
        take_fetch = fetch_valid;
`else
        take_fetch = fetch_valid & (~data_pend | rr_last_data);
`endif
        next_grant = G_LOAD;
        if (take_fetch) begin
            next_grant = G_FETCH;
        end else if (store_valid) begin
            next_grant = G_STORE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            grant         <= G_FETCH;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_last_data  <= 1'b1;
`endif
            fetch_data    <= '0;
            fetch_ready   <= 1'b0;
            load_data     <= '0;
            load_ready    <= 1'b0;
            store_ready   <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_req_valid <= 1'b0;
        end else begin
            // NOTE: ready strobes default low every cycle so each completion pulse is exactly one clock wide.
            fetch_ready <= 1'b0;
            load_ready  <= 1'b0;
            store_ready <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (take_any) begin
                        grant         <= next_grant;
                        mem_req_valid <= 1'b1;
                        mem_we        <= (next_grant == G_STORE);
                        mem_wdata     <= (next_grant == G_STORE) ? store_data : '0;
                        case (next_grant)
                            G_FETCH: mem_addr <= fetch_addr;
                            G_STORE: mem_addr <= store_addr;
                            default: mem_addr <= load_addr;
                        endcase
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_we) begin
                            store_ready <= 1'b1;
                            state       <= S_RESPOND;
                        end else begin
                            state <= S_WAIT_RD;
                        end
                    end
                end

                S_WAIT_RD: begin
                    if (mem_resp_valid) begin
                        if (grant == G_FETCH) begin
                            fetch_data  <= mem_resp_data;
                            fetch_ready <= 1'b1;
                        end else begin
                            load_data  <= mem_resp_data;
                            load_ready <= 1'b1;
                        end
                        state <= S_RESPOND;
                    end
                end

                S_RESPOND: begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                    rr_last_data <= (grant != G_FETCH);
`endif
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified memory port between the instruction fetcher (reads) and the executor (loads and stores). Lets the core run against a single-ported memory instead of separate instruction and main memories. Sits between the fetcher/executor memory handshakes and the memory controller. Keeps at most one transaction outstanding and grants requesters by round-robin; a compile-time option switches this to fixed priority.

## Interface
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width for all ports
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_addr  in  ADDR_W  instruction read address
- fetch_valid  in  1  fetch read request, held until fetch_ready
- fetch_data  out  DATA_W  read data, valid while fetch_ready=1
- fetch_ready  out  1  one-cycle completion pulse
- load_addr  in  ADDR_W  executor load address
- load_valid  in  1  load request, held until load_ready
- load_data  out  DATA_W  load data, valid while load_ready=1
- load_ready  out  1  one-cycle completion pulse
- store_addr / store_data  in  ADDR_W / DATA_W  executor store request
- store_valid  in  1  store request, held until store_ready
- store_ready  out  1  one-cycle completion pulse
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  downstream request fields
- mem_we  out  1  1 = write, 0 = read
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  request accepted when valid&ready
- mem_resp_valid  in  1  one-cycle read-data pulse
- mem_resp_data  in  DATA_W  read data, valid with mem_resp_valid

## Operation
- States: IDLE, ISSUE, WAIT_RD, RESPOND.
- IDLE: sample the three valids. Data side = store if store_valid, else load. If fetch and data both pending, grant the side not granted last (rr_last flag; reset value = data, so fetch wins first). Latch addr/wdata/we/grant into registers, then go to ISSUE.
- ISSUE: mem_req_valid=1 with the latched fields. On mem_req_ready go to WAIT_RD for a read, or RESPOND for a write.
- WAIT_RD: wait for mem_resp_valid. Capture mem_resp_data into the response register, then go to RESPOND.
- RESPOND: pulse the granted requester's ready for exactly one cycle with data. Update rr_last, then go to IDLE.
- Requests are never reordered. Store beats load when both are asserted together.
- A mem_resp_valid arriving outside WAIT_RD is ignored.
- Reset (asynchronous assert, any state): state=IDLE, rr_last=data. All outputs 0: every ready, mem_req_valid, mem_we, addr/data buses. The in-flight transaction is dropped. The memory must be reset alongside the arbiter.

## Timing
- Every output is registered; no combinational path from input to output.
- Read, zero-wait memory: valid seen in IDLE at cycle T; mem_req_valid at T+1. With ready at T+1 and resp at T+2, the requester ready pulse is at T+3.
- Write: valid at T; mem_req_valid at T+1; accepted at T+1; store_ready at T+2.
- mem_req_valid and its fields stay stable from assertion until accepted.
- Requester protocol: valid and fields held until its ready pulse (cycle R). Valid must be low in R+1, or it is taken as a new request in IDLE at R+1.
- Minimum spacing between back-to-back transactions: 3 cycles for writes, 4 for reads.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: fetch always wins over data and rr_last is unused. Data can starve while fetch_valid is held high.
- Not defined: round-robin alternation as above. With continuous requests on both sides, grants alternate fetch, data, fetch, …

## Test plan
- Single fetch, addr 0x100, memory returns 0xDEADBEEF one cycle after accept. Required: mem_we=0, mem_addr=0x100, fetch_ready pulse at T+3 with fetch_data=0xDEADBEEF; load_ready and store_ready stay 0.
- Store to 0x200 data 0x12345678, mem_req_ready delayed 4 cycles. Required: fields stable for all 4 cycles, mem_we=1, store_ready exactly one cycle after accept.
- fetch_valid and load_valid held continuously for 6 transactions. Required: grants F,L,F,L,F,L. With MEM_ARB_FIXED_PRIO_EN defined: 6 fetches and no load_ready.
- store_valid and load_valid asserted in the same cycle. Required: store issued first, then load, each ready pulsing once.
- Reset asserted in WAIT_RD. Required: all outputs 0 immediately. After release, a stale mem_resp_valid produces no ready, and the next fetch completes normally.
- mem_resp_valid pulsed while IDLE. Required: no ready pulse and state unchanged.
